vga_pattern_display: RTL and testbench
======================================

Name: vga_pattern_display

Overview:
Parametrised successor to the fixed 640x480 display controller. It takes the board clock, derives a pixel-rate enable internally, and generates HSYNC/VSYNC timing for any resolution set at elaboration. It drives RGB with configurable per-channel depth, from one of four runtime-selectable sources. Colour and mode inputs are shadowed at frame boundaries so the picture never tears.

Parameters:
CLK_DIV, 2, boardClk cycles per pixel (>=1; 1 = enable always high)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, asserted level of vgaHsync
V_POL, 0, asserted level of vgaVsync
COLOR_BITS, 3, bits per colour channel

Ports:
boardClk  in  1  system clock
reset  in  1  asynchronous, active-low reset
colorIn  in  3*COLOR_BITS  solid/checker colour {R,G,B}
modeSel  in  2  0 solid, 1 colour bars, 2 checkerboard, 3 grey gradient
vgaRGB  out  3*COLOR_BITS  pixel colour {R,G,B}
vgaHsync  out  1  horizontal sync
vgaVsync  out  1  vertical sync
pixelX  out  11  column of the pixel currently on vgaRGB
pixelY  out  11  line of the pixel currently on vgaRGB
frameStart  out  1  one boardClk pulse when pixel (0,0) is output

Behaviour:
- Clock and reset: single clock boardClk; reset asynchronous, active-low.
- Pixel enable (pe): divider counts 0..CLK_DIV-1; pe is high when the count is CLK_DIV-1. All counters and outputs update only on pe.
- Line and frame totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- hCount: runs 0..H_TOTAL-1 and wraps to 0.
- vCount: increments on each hCount wrap; wraps to 0 after V_TOTAL-1.
- Active region: hCount<H_ACTIVE and vCount<V_ACTIVE.
- Hsync asserted: H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC.
- Vsync asserted: V_ACTIVE+V_FP <= vCount < V_ACTIVE+V_FP+V_SYNC (whole lines).
- Output levels: vgaHsync = H_POL when asserted, ~H_POL otherwise. Same rule for vgaVsync with V_POL.
- Output pipeline: every output is registered. On each pe the outputs take values computed from the current counters, so there is one pixel of latency. vgaRGB, both syncs, pixelX and pixelY are always mutually aligned.
- Blanking: vgaRGB = 0 whenever the counters are outside the active region. pixelX/pixelY still track hCount/vCount during blanking.
- Shadow registers: colorIn and modeSel are captured on the pe where hCount=H_TOTAL-1 and vCount=V_TOTAL-1. The new values therefore take effect exactly at pixel (0,0) of the next frame. Mid-frame input changes are ignored.
- Mode 0 (solid): RGB = shadow colour.
- Mode 1 (colour bars): bar index i = hCount / (H_ACTIVE/8), clamped to 7.
  - R = all-ones if i[2], else 0; G from i[1]; B from i[0].
- Mode 2 (checkerboard): if (hCount[5] XOR vCount[5]) = 1, RGB = shadow colour; otherwise 0.
- Mode 3 (grey gradient): each channel = (hCount * 2^COLOR_BITS) / H_ACTIVE. Computed with a constant-divisor approach or a per-pixel accumulator; no runtime divider.
- frameStart: high for the single boardClk cycle following the pe that loads pixelX=0, pixelY=0. Low at all other times.
- Reset values (immediate on reset low): divider 0, hCount 0, vCount 0, vgaRGB 0, vgaHsync=~H_POL, vgaVsync=~V_POL, pixelX 0, pixelY 0, frameStart 0, shadow colour 0, shadow mode 0.
- First frame after reset release: (0,0) is loaded on the first pe, but frameStart is NOT asserted, because the prior state is reset rather than a frame end.
- Reset mid-frame: everything returns to the reset values immediately, and the next frame starts from (0,0).
- Widths: counters are 11 bits. Elaboration must fail (assertion) if H_TOTAL or V_TOTAL exceeds 2047, or if CLK_DIV < 1.

Test Plan:
- Reset held 5 cycles, with defaults: vgaRGB=0, vgaHsync=1, vgaVsync=1, pixelX=pixelY=0, frameStart=0. After release, pe pulses every 2nd cycle.
- Default line timing: hsync period 1600 boardClk cycles; low for 192 cycles, starting on the pe that outputs pixelX=656. vsync low for pixelY 490–491; frame length = 420000 pe (840000 cycles).
- Mode 0, colorIn=9'o705 set at line 100 of frame N: frame N shows the previous colour. Frame N+1 shows 9'o705 from (0,0); RGB is 0 at pixelX 640–799.
- Mode 1, defaults: pixelX 0–79 → 9'o000; 80–159 → 9'o007; 560–639 → 9'o777.
- Mode 2, colorIn=9'o070: (0,0) → 0; (32,0) → 9'o070; (32,32) → 0.
- Mode 3, with CLK_DIV=1, H_ACTIVE=16, V_ACTIVE=4, porches/syncs=2, COLOR_BITS=3, H_POL=1: the channel steps by 1 every 2 pixels (0..7); hsync is high for 2 pe; frameStart pulses every 22*10 cycles. Reset asserted mid-frame → outputs return to reset values immediately.

Source files
------------

// File: rtl/vga_pattern_display.sv
// Parametrised VGA timing generator with four selectable test-pattern sources.
// Colour and mode are shadowed at the frame boundary; all outputs are registered and aligned.
module vga_pattern_display #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_POL      = 0,
    parameter int V_POL      = 0,
    parameter int COLOR_BITS = 3
) (
    input  logic                      boardClk,
    input  logic                      reset,
    input  logic [3*COLOR_BITS-1:0]   colorIn,
    input  logic [1:0]                modeSel,
    output logic [3*COLOR_BITS-1:0]   vgaRGB,
    output logic                      vgaHsync,
    output logic                      vgaVsync,
    output logic [10:0]               pixelX,
    output logic [10:0]               pixelY,
    output logic                      frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW      = 3 * COLOR_BITS;
    localparam int GW      = 11 + COLOR_BITS;
    localparam int BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BAR_DIV  = 11'(BAR_W);
    localparam logic [GW-1:0] GREY_DIV = GW'(H_ACTIVE);
    localparam logic H_ON = 1'(H_POL);
    localparam logic V_ON = 1'(V_POL);

    generate
        if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : gTotalCheck
            $fatal(1, "vga_pattern_display: H_TOTAL or V_TOTAL exceeds 11-bit counter range");
        end
        if (CLK_DIV < 1) begin : gDivCheck
            $fatal(1, "vga_pattern_display: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0] divCnt_r;
    logic [10:0]      hCount_r;
    logic [10:0]      vCount_r;
    logic [CW-1:0]    shadowColor_r;
    logic [1:0]       shadowMode_r;
    logic             started_r;

    logic             pe_s;
    logic             lastPix_s;
    logic             lastLine_s;
    logic             active_s;
    logic             hsAct_s;
    logic             vsAct_s;
    logic [10:0]      barRaw_s;
    logic [2:0]       barIdx_s;
    logic [COLOR_BITS-1:0] grey_s;
    logic [CW-1:0]    pixel_s;

    assign pe_s       = (divCnt_r == DIV_LAST);
    assign lastPix_s  = (hCount_r == H_LAST);
    assign lastLine_s = (vCount_r == V_LAST);
    assign active_s   = (hCount_r < H_ACT) && (vCount_r < V_ACT);
    assign hsAct_s    = (hCount_r >= HS_START) && (hCount_r < HS_END);
    assign vsAct_s    = (vCount_r >= VS_START) && (vCount_r < VS_END);
    assign barRaw_s   = hCount_r / BAR_DIV;
    assign barIdx_s   = (barRaw_s > 11'd7) ? 3'd7 : barRaw_s[2:0];
    // Divisor is an elaboration constant, so this reduces to fixed logic.
    assign grey_s     = COLOR_BITS'({hCount_r, {COLOR_BITS{1'b0}}} / GREY_DIV);

    // Pixel-rate divider.
    always_ff @(posedge boardClk or negedge reset) begin
        if (!reset)     divCnt_r <= '0;
        else if (pe_s)  divCnt_r <= '0;
        else            divCnt_r <= divCnt_r + DIV_ONE;
    end

    // Horizontal and vertical raster counters.
    always_ff @(posedge boardClk or negedge reset) begin
        if (!reset) begin
            hCount_r <= 11'd0;
            vCount_r <= 11'd0;
        end else if (pe_s) begin
            if (lastPix_s) begin
                hCount_r <= 11'd0;
                vCount_r <= lastLine_s ? 11'd0 : (vCount_r + 11'd1);
            end else begin
                hCount_r <= hCount_r + 11'd1;
            end
        end
    end

    // Capture colour/mode on the final pixel so they apply from (0,0) of the next frame.
    always_ff @(posedge boardClk or negedge reset) begin
        if (!reset) begin
            shadowColor_r <= '0;
            shadowMode_r  <= 2'd0;
        end else if (pe_s && lastPix_s && lastLine_s) begin
            shadowColor_r <= colorIn;
            shadowMode_r  <= modeSel;
        end
    end

    // Pattern selection for the pixel at the current counters.
    always_comb begin
        pixel_s = '0;
        if (!active_s) begin
            pixel_s = '0;
        end else begin
            case (shadowMode_r)
                2'd0: pixel_s = shadowColor_r;
                2'd1: pixel_s = {{COLOR_BITS{barIdx_s[2]}}, {COLOR_BITS{barIdx_s[1]}},
                                 {COLOR_BITS{barIdx_s[0]}}};
                2'd2: begin
                    if (hCount_r[5] ^ vCount_r[5]) pixel_s = shadowColor_r;
                    else                           pixel_s = '0;
                end
                2'd3: pixel_s = {3{grey_s}};
                default: pixel_s = '0;
            endcase
        end
    end

    // Registered, mutually aligned video outputs.
    always_ff @(posedge boardClk or negedge reset) begin
        if (!reset) begin
            vgaRGB   <= '0;
            vgaHsync <= ~H_ON;
            vgaVsync <= ~V_ON;
            pixelX   <= 11'd0;
            pixelY   <= 11'd0;
        end else if (pe_s) begin
            vgaRGB   <= pixel_s;
            vgaHsync <= hsAct_s ? H_ON : ~H_ON;
            vgaVsync <= vsAct_s ? V_ON : ~V_ON;
            pixelX   <= hCount_r;
            pixelY   <= vCount_r;
        end
    end

    // Frame marker; suppressed for the first (0,0) after reset since no frame ended.
    always_ff @(posedge boardClk or negedge reset) begin
        if (!reset) begin
            frameStart <= 1'b0;
            started_r  <= 1'b0;
        end else begin
            frameStart <= pe_s && started_r && (hCount_r == 11'd0) && (vCount_r == 11'd0);
            started_r  <= started_r | pe_s;
        end
    end

endmodule

// File: tb/tb_vga_pattern_display.sv
// Directed bench: one default instance for line timing, two short-frame instances for
// shadowing and patterns, and a tiny instance for the grey gradient and mid-frame reset.
module tb_vga_pattern_display;

    logic boardClk = 1'b0;
    logic rstMain, rstS;
    logic [8:0] colorD, colorM, colorC, colorS;
    logic [1:0] modeD, modeM, modeC, modeS;

    logic [8:0]  rgbD, rgbM, rgbC, rgbS;
    logic        hsD, hsM, hsC, hsS, vsD, vsM, vsC, vsS, fsD, fsM, fsC, fsS;
    logic [10:0] pxD, pxM, pxC, pxS, pyD, pyM, pyC, pyS;

    int nComp, nFail, edgeN;

    always #5 boardClk = ~boardClk;

    vga_pattern_display dutD (
        .boardClk(boardClk), .reset(rstMain), .colorIn(colorD), .modeSel(modeD),
        .vgaRGB(rgbD), .vgaHsync(hsD), .vgaVsync(vsD), .pixelX(pxD), .pixelY(pyD),
        .frameStart(fsD));

    vga_pattern_display #(.CLK_DIV(1), .V_ACTIVE(33), .V_FP(1), .V_SYNC(2), .V_BP(1)) dutM (
        .boardClk(boardClk), .reset(rstMain), .colorIn(colorM), .modeSel(modeM),
        .vgaRGB(rgbM), .vgaHsync(hsM), .vgaVsync(vsM), .pixelX(pxM), .pixelY(pyM),
        .frameStart(fsM));

    vga_pattern_display #(.CLK_DIV(1), .V_ACTIVE(33), .V_FP(1), .V_SYNC(2), .V_BP(1)) dutC (
        .boardClk(boardClk), .reset(rstMain), .colorIn(colorC), .modeSel(modeC),
        .vgaRGB(rgbC), .vgaHsync(hsC), .vgaVsync(vsC), .pixelX(pxC), .pixelY(pyC),
        .frameStart(fsC));

    vga_pattern_display #(.CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
                          .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
                          .COLOR_BITS(3), .H_POL(1)) dutS (
        .boardClk(boardClk), .reset(rstS), .colorIn(colorS), .modeSel(modeS),
        .vgaRGB(rgbS), .vgaHsync(hsS), .vgaVsync(vsS), .pixelX(pxS), .pixelY(pyS),
        .frameStart(fsS));

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkPos(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkRgb(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %o expected %o", tag, obs, exp);
        end
    endtask

    // Edge k is the k-th rising edge after reset release; sample 1 ns after it.
    task automatic gotoEdge(input int k);
        while (edgeN < k) begin
            @(posedge boardClk);
            edgeN++;
        end
        #1;
    endtask

    initial begin
        nComp = 0; nFail = 0; edgeN = 0;
        rstMain = 1'b0; rstS = 1'b0;
        colorD = 9'o000; modeD = 2'd0;
        colorM = 9'o123; modeM = 2'd0;
        colorC = 9'o000; modeC = 2'd0;
        colorS = 9'o000; modeS = 2'd3;

        repeat (5) @(posedge boardClk);
        #1;
        chkRgb("rst_rgb", rgbD, 9'o000);
        chkBit("rst_hs", hsD, 1'b1);
        chkBit("rst_vs", vsD, 1'b1);
        chkPos("rst_px", pxD, 11'd0);
        chkPos("rst_py", pyD, 11'd0);
        chkBit("rst_fs", fsD, 1'b0);
        chkBit("rst_hs_pol1", hsS, 1'b0);
        chkBit("rst_vs_small", vsS, 1'b1);
        rstMain = 1'b1; rstS = 1'b1;

        // First pixel after release: no frameStart; divide-by-2 pe cadence.
        gotoEdge(1);  chkBit("first_fs_m", fsM, 1'b0); chkBit("first_fs_s", fsS, 1'b0);
                      chkPos("first_px_m", pxM, 11'd0);
        gotoEdge(2);  chkPos("pe_px_d2", pxD, 11'd0); chkPos("pe_px_m2", pxM, 11'd1);
                      chkPos("pe_px_s2", pxS, 11'd1);
        gotoEdge(3);  chkPos("pe_px_d3", pxD, 11'd0);
        gotoEdge(4);  chkPos("pe_px_d4", pxD, 11'd1);
        gotoEdge(6);  chkPos("pe_px_d6", pxD, 11'd2);

        // Small instance: frame 0 is black, frame 1 is the grey gradient.
        gotoEdge(16);  chkPos("s_f0_px", pxS, 11'd15); chkRgb("s_f0_rgb", rgbS, 9'o000);
        gotoEdge(221); chkBit("s_fs1", fsS, 1'b1); chkPos("s_fs1_px", pxS, 11'd0);
                       chkPos("s_fs1_py", pyS, 11'd0); chkRgb("s_grey0", rgbS, 9'o000);
        gotoEdge(222); chkBit("s_fs1_end", fsS, 1'b0); chkRgb("s_grey1", rgbS, 9'o000);
        gotoEdge(223); chkRgb("s_grey2", rgbS, 9'o111);
        gotoEdge(226); chkRgb("s_grey5", rgbS, 9'o222);
        gotoEdge(236); chkRgb("s_grey15", rgbS, 9'o777); chkPos("s_px15", pxS, 11'd15);
        gotoEdge(237); chkRgb("s_blank16", rgbS, 9'o000);
        gotoEdge(238); chkBit("s_hs17", hsS, 1'b0);
        gotoEdge(239); chkBit("s_hs18", hsS, 1'b1); chkPos("s_px18", pxS, 11'd18);
        gotoEdge(240); chkBit("s_hs19", hsS, 1'b1); chkRgb("s_rgb19", rgbS, 9'o000);
        gotoEdge(241); chkBit("s_hs20", hsS, 1'b0);
        gotoEdge(352); chkBit("s_vs_row5", vsS, 1'b1);
        gotoEdge(353); chkBit("s_vs_row6", vsS, 1'b0); chkPos("s_py6", pyS, 11'd6);
        gotoEdge(441); chkBit("s_fs2", fsS, 1'b1);
        gotoEdge(442); chkBit("s_fs2_end", fsS, 1'b0);

        // Mid-frame reset on the small instance.
        gotoEdge(478); chkPos("s_pre_px", pxS, 11'd15); chkPos("s_pre_py", pyS, 11'd1);
                       chkRgb("s_pre_rgb", rgbS, 9'o777);
        rstS = 1'b0;
        #1;
        chkRgb("s_mid_rst_rgb", rgbS, 9'o000);
        chkBit("s_mid_rst_hs", hsS, 1'b0);
        chkBit("s_mid_rst_vs", vsS, 1'b1);
        chkPos("s_mid_rst_px", pxS, 11'd0);
        chkPos("s_mid_rst_py", pyS, 11'd0);
        chkBit("s_mid_rst_fs", fsS, 1'b0);
        rstS = 1'b1;
        gotoEdge(479); chkPos("s_rel_px", pxS, 11'd0); chkPos("s_rel_py", pyS, 11'd0);
                       chkBit("s_rel_fs", fsS, 1'b0); chkRgb("s_rel_rgb", rgbS, 9'o000);
        gotoEdge(480); chkPos("s_rel_px1", pxS, 11'd1);

        // Default instance line timing: sync low for pixels 656..751, period 1600 clocks.
        gotoEdge(1313); chkBit("d_hs655", hsD, 1'b1); chkPos("d_px655", pxD, 11'd655);
        gotoEdge(1314); chkBit("d_hs656", hsD, 1'b0); chkPos("d_px656", pxD, 11'd656);
                        chkBit("d_vs_l0", vsD, 1'b1);
        gotoEdge(1505); chkBit("d_hs751", hsD, 1'b0); chkPos("d_px751", pxD, 11'd751);
        gotoEdge(1506); chkBit("d_hs752", hsD, 1'b1); chkPos("d_px752", pxD, 11'd752);
        gotoEdge(2913); chkBit("d_hs_l1_655", hsD, 1'b1);
        gotoEdge(2914); chkBit("d_hs_l1_656", hsD, 1'b0); chkPos("d_py_l1", pyD, 11'd1);
                        chkPos("d_px_l1", pxD, 11'd656); chkRgb("d_rgb", rgbD, 9'o000);

        // Change inputs mid-frame 0 (line 10).
        gotoEdge(8001); chkPos("m_py10", pyM, 11'd10); chkPos("m_px10", pxM, 11'd0);
        colorM = 9'o705;
        colorC = 9'o070; modeC = 2'd2;
        gotoEdge(16001); chkRgb("m_f0_old", rgbM, 9'o000); chkPos("m_py20", pyM, 11'd20);
        gotoEdge(27200); chkBit("m_vs33", vsM, 1'b1); chkPos("m_py33", pyM, 11'd33);
        gotoEdge(27201); chkBit("m_vs34", vsM, 1'b0); chkPos("m_py34", pyM, 11'd34);
        gotoEdge(28800); chkBit("m_vs35", vsM, 1'b0);
        gotoEdge(28801); chkBit("m_vs36", vsM, 1'b1); chkPos("m_py36", pyM, 11'd36);
        gotoEdge(29600); chkPos("m_last_px", pxM, 11'd799); chkBit("m_last_fs", fsM, 1'b0);
        gotoEdge(29601); chkBit("m_fs1", fsM, 1'b1); chkPos("m_f1_px", pxM, 11'd0);
                         chkPos("m_f1_py", pyM, 11'd0); chkRgb("m_f1_rgb0", rgbM, 9'o705);
                         chkRgb("c_00", rgbC, 9'o000);
        gotoEdge(29602); chkBit("m_fs1_end", fsM, 1'b0); chkRgb("m_f1_rgb1", rgbM, 9'o705);
        gotoEdge(29633); chkRgb("c_32_0", rgbC, 9'o070);
        gotoEdge(30240); chkRgb("m_f1_rgb639", rgbM, 9'o705);
        gotoEdge(30241); chkRgb("m_f1_rgb640", rgbM, 9'o000); chkPos("m_px640", pxM, 11'd640);
        gotoEdge(30400); chkRgb("m_f1_rgb799", rgbM, 9'o000); chkPos("m_px799", pxM, 11'd799);

        // Switch to colour bars mid-frame 1; frame 1 must keep the solid colour.
        gotoEdge(37601); chkPos("m_f1_py10", pyM, 11'd10);
        modeM = 2'd1; colorM = 9'o000;
        gotoEdge(45601); chkRgb("m_f1_ignore", rgbM, 9'o705);
        gotoEdge(55201); chkRgb("c_0_32", rgbC, 9'o070);
        gotoEdge(55233); chkRgb("c_32_32", rgbC, 9'o000);

        // Frame 2: colour bars.
        gotoEdge(59201); chkRgb("bar_x0", rgbM, 9'o000); chkBit("m_fs2", fsM, 1'b1);
        gotoEdge(59280); chkRgb("bar_x79", rgbM, 9'o000);
        gotoEdge(59281); chkRgb("bar_x80", rgbM, 9'o007);
        gotoEdge(59360); chkRgb("bar_x159", rgbM, 9'o007);
        gotoEdge(59441); chkRgb("bar_x240", rgbM, 9'o077);
        gotoEdge(59761); chkRgb("bar_x560", rgbM, 9'o777);
        gotoEdge(59840); chkRgb("bar_x639", rgbM, 9'o777);
        gotoEdge(59841); chkRgb("bar_x640", rgbM, 9'o000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
